traffic_scheduler: RTL and testbench

//  Multi-phase intersection scheduler that replaces the fixed two-road controller.

---
 rtl/traffic_pkg.sv | 5 +
 rtl/rr_pick.sv | 22 ++
 rtl/traffic_scheduler.sv | 87 ++++++++
 tb/tb_traffic_scheduler.sv | 131 +++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: lamp colour and scheduler state encodings shared by the scheduler and its benches.
package traffic_pkg;
    typedef enum logic [1:0] {GREEN = 2'd0, YELLOW = 2'd1, RED = 2'd2} colour_t;
    typedef enum logic [2:0] {ST_IDLE, ST_GREEN, ST_YELLOW, ST_ALLRED, ST_WALK} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick of the first set request at or after ptr.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] idx,
    output logic          any
);
    logic [PW-1:0] k;
    // Scan offsets from farthest to nearest so the nearest set request is the last to win.
    always_comb begin
        idx = '0;
        k = '0;
        for (int i = N - 1; i >= 0; i--) begin
            k = PW'((int'(ptr) + i) % N);
            if (req[k]) idx = k;
        end
    end
    assign any = |req;
endmodule

// File: rtl/traffic_scheduler.sv
// traffic_scheduler: round-robin multi-phase intersection scheduler with pedestrian walk phase.
module traffic_scheduler
    import traffic_pkg::*;
#(
    parameter int N_PH      = 4,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 12,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_PH-1:0]         req,
    input  logic                    ped_btn,
    output logic [2*N_PH-1:0]       lights,
    output logic                    walk,
    output logic [$clog2(N_PH)-1:0] grant_ph,
    output logic                    grant_vld
);
    localparam int PW   = $clog2(N_PH);
    localparam int T1   = GREEN_MAX > WALK_T ? GREEN_MAX : WALK_T;
    localparam int T2   = YELLOW_T > ALLRED_T ? YELLOW_T : ALLRED_T;
    localparam int CW   = $clog2(T1 > T2 ? T1 : T2) + 1;
    localparam logic [CW-1:0] G_MIN = CW'(GREEN_MIN - 1);
    localparam logic [CW-1:0] G_MAX = CW'(GREEN_MAX - 1);
    localparam logic [CW-1:0] Y_END = CW'(YELLOW_T - 1);
    localparam logic [CW-1:0] A_END = CW'(ALLRED_T - 1);
    localparam logic [CW-1:0] W_END = CW'(WALK_T - 1);

    state_t              state, nxt;
    logic [PW-1:0]       g, nxt_g, ptr, pick;
    logic [CW-1:0]       cnt;
    logic [2*N_PH-1:0]   nxt_lights;
    logic                any, pend, other, dec, d_walk, last_walk, ped_pend;

    // A press in the current cycle counts immediately, so walk/yield react with one cycle latency.
    assign pend   = ped_pend | ped_btn;
    assign other  = |(req & ~(N_PH'(1) << g)) | pend;
    assign d_walk = pend && !(last_walk && any);

    rr_pick #(.N(N_PH), .PW(PW)) u_pick (.req(req), .ptr(ptr), .idx(pick), .any(any));

    always_comb begin
        nxt = state;
        dec = 1'b0;
        case (state)
            ST_IDLE:   dec = 1'b1;
            ST_GREEN:  if (other && ((cnt >= G_MIN && !req[g]) || cnt == G_MAX)) nxt = ST_YELLOW;
            ST_YELLOW: if (cnt == Y_END) nxt = ST_ALLRED;
            ST_ALLRED: dec = cnt == A_END;
            ST_WALK:   if (cnt == W_END) nxt = ST_ALLRED;
            default:   nxt = ST_IDLE;
        endcase
        if (dec) nxt = d_walk ? ST_WALK : any ? ST_GREEN : ST_IDLE;
        nxt_g = dec && !d_walk && any ? pick : g;
        nxt_lights = {N_PH{RED}};
        for (int i = 0; i < N_PH; i++)
            nxt_lights[2*i +: 2] = nxt_g != PW'(i) ? RED : nxt == ST_GREEN ? GREEN : nxt == ST_YELLOW ? YELLOW : RED;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            g         <= '0;
            ptr       <= '0;
            cnt       <= '0;
            ped_pend  <= 1'b0;
            last_walk <= 1'b0;
            lights    <= {N_PH{RED}};
            walk      <= 1'b0;
            grant_ph  <= '0;
            grant_vld <= 1'b0;
        end else begin
            state     <= nxt;
            g         <= nxt_g;
            cnt       <= nxt != state ? '0 : (state == ST_GREEN && cnt == G_MAX) ? cnt : cnt + 1'b1;
            if (state == ST_YELLOW && nxt == ST_ALLRED) ptr <= g == PW'(N_PH - 1) ? '0 : g + 1'b1;
            ped_pend  <= ped_btn || (ped_pend && !(nxt == ST_WALK && state != ST_WALK));
            if (dec && (d_walk || any)) last_walk <= d_walk;
            lights    <= nxt_lights;
            walk      <= nxt == ST_WALK;
            grant_vld <= nxt == ST_GREEN || nxt == ST_YELLOW;
            grant_ph  <= (nxt == ST_GREEN || nxt == ST_YELLOW) ? nxt_g : '0;
        end
    end
endmodule

// File: tb/tb_traffic_scheduler.sv
// tb_traffic_scheduler: directed self-checking bench for traffic_scheduler at default parameters.
module tb_traffic_scheduler;
    import traffic_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ped_btn = 1'b0;
    logic [3:0] req = 4'b0;
    logic [7:0] lights;
    logic       walk, grant_vld;
    logic [1:0] grant_ph;
    int         n_vec = 0;
    int         n_err = 0;
    int         ylen[4];
    int         nr;

    always #5 clk = ~clk;

    traffic_scheduler dut (
        .clk(clk), .rst(rst), .req(req), .ped_btn(ped_btn),
        .lights(lights), .walk(walk), .grant_ph(grant_ph), .grant_vld(grant_vld)
    );

    function automatic logic [7:0] lamp(input int ph, input logic [1:0] col);
        logic [7:0] v;
        v = 8'hAA;
        if (ph >= 0) v[2*ph +: 2] = col;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ph = -1 means every phase red.
    task automatic expect_n(input string tag, input int n, input int ph, input logic [1:0] col, input logic w);
        repeat (n) begin
            tick();
            chk({tag, "_lights"}, 32'(lights), 32'(lamp(ph, col)));
            chk({tag, "_walk"}, 32'(walk), 32'(w));
            chk({tag, "_vld"}, 32'(grant_vld), 32'(ph >= 0));
            chk({tag, "_ph"}, 32'(grant_ph), 32'(ph >= 0 ? ph : 0));
        end
    endtask

    // Safety invariants watched on every falling edge.
    always @(negedge clk) begin
        nr = 0;
        for (int i = 0; i < 4; i++) if (lights[2*i +: 2] != RED) nr++;
        chk("one_nonred", 32'(nr <= 1), 32'd1);
        chk("walk_allred", 32'(!(walk && lights != 8'hAA)), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (rst) ylen[i] = 0;
            else if (lights[2*i +: 2] == YELLOW) ylen[i]++;
            else begin
                if (ylen[i] != 0) chk("yellow_len", 32'(ylen[i]), 32'd2);
                ylen[i] = 0;
            end
        end
    end

    initial begin
        expect_n("rst", 2, -1, RED, 1'b0);
        rst = 1'b0;
        req = 4'b0010;
        expect_n("t2_g1", 30, 1, GREEN, 1'b0);
        #3 rst = 1'b1;
        #1;
        chk("t1_async_lights", 32'(lights), 32'hAA);
        chk("t1_async_walk", 32'(walk), 32'd0);
        chk("t1_async_vld", 32'(grant_vld), 32'd0);
        req = 4'b0;
        tick();
        rst = 1'b0;
        expect_n("t1_idle", 2, -1, RED, 1'b0);
        req = 4'b0101;
        expect_n("t3_g0", 12, 0, GREEN, 1'b0);
        expect_n("t3_y0", 2, 0, YELLOW, 1'b0);
        expect_n("t3_ar0", 1, -1, RED, 1'b0);
        expect_n("t3_g2", 12, 2, GREEN, 1'b0);
        expect_n("t3_y2", 2, 2, YELLOW, 1'b0);
        expect_n("t3_ar2", 1, -1, RED, 1'b0);
        expect_n("t3_g0b", 3, 0, GREEN, 1'b0);
        rst = 1'b1;
        req = 4'b0;
        tick();
        rst = 1'b0;
        req = 4'b0010;
        expect_n("t4_g1", 6, 1, GREEN, 1'b0);
        req = 4'b0;
        ped_btn = 1'b1;
        expect_n("t4_y1a", 1, 1, YELLOW, 1'b0);
        ped_btn = 1'b0;
        expect_n("t4_y1b", 1, 1, YELLOW, 1'b0);
        expect_n("t4_ar", 1, -1, RED, 1'b0);
        expect_n("t4_walk", 6, -1, RED, 1'b1);
        expect_n("t4_ar2", 1, -1, RED, 1'b0);
        expect_n("t4_idle", 3, -1, RED, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ped_btn = 1'b1;
        req = 4'b1000;
        expect_n("t5_walk_a", 1, -1, RED, 1'b1);
        ped_btn = 1'b0;
        expect_n("t5_walk_b", 2, -1, RED, 1'b1);
        ped_btn = 1'b1;
        expect_n("t5_walk_c", 1, -1, RED, 1'b1);
        ped_btn = 1'b0;
        expect_n("t5_walk_d", 2, -1, RED, 1'b1);
        expect_n("t5_ar", 1, -1, RED, 1'b0);
        expect_n("t5_g3", 5, 3, GREEN, 1'b0);
        req = 4'b0;
        expect_n("t5_y3", 2, 3, YELLOW, 1'b0);
        expect_n("t5_ar2", 1, -1, RED, 1'b0);
        expect_n("t5_walk2", 6, -1, RED, 1'b1);
        expect_n("t5_ar3", 1, -1, RED, 1'b0);
        expect_n("t5_idle", 3, -1, RED, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
